// File: rtl/n_addsub_pipe.sv
// n_addsub_pipe: two-stage pipelined add/subtract unit with valid/ready
// handshaking, four operation modes and registered status flags.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       operands/op valid this cycle
//   in_ready       unit can accept (transfer on in_valid && in_ready)
//   op             2'b00 ADD, 2'b01 SUB, 2'b10 ABSDIFF, 2'b11 SATADD
//   A, B           N-bit operands
//   out_valid      result and flags valid
//   out_ready      consumer accepts (transfer on out_valid && out_ready)
//   z              N-bit result
//   cout           carry (ADD/SATADD) or borrow (SUB/ABSDIFF)
//   negative_flag  sign of result (ADD/SUB), borrow (ABSDIFF), 0 (SATADD)
//   zero_flag      z == 0
//   overflow_flag  signed overflow (ADD/SUB), saturation (SATADD), 0 (ABSDIFF)
//
// Stage 1 registers the operands; the arithmetic is evaluated combinationally
// from stage 1 and captured into stage 2, which drives every output.
module n_addsub_pipe #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z,
    output logic         cout,
    output logic         negative_flag,
    output logic         zero_flag,
    output logic         overflow_flag
);

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ABSDIFF = 2'b10,
        OP_SATADD  = 2'b11
    } op_e;

    // Stage 1
    logic [N-1:0] a_q, b_q;
    op_e          op_q;
    logic         s1_valid_q;

    // Stage 2
    logic [N-1:0] z_q;
    logic         cout_q, neg_q, zero_q, ovf_q;
    logic         s2_valid_q;

    // Next-state values for stage 2
    logic [N-1:0] z_d;
    logic         cout_d, neg_d, zero_d, ovf_d;

    logic [N:0]   sum;
    logic [N:0]   dif;
    logic         borrow;
    logic         adv;
    logic         accept;

    // Stage 2 can take new data when empty or being drained this cycle.
    assign adv      = !s2_valid_q || out_ready;
    assign in_ready = rst_n && (!s1_valid_q || adv);
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum    = {1'b0, a_q} + {1'b0, b_q};
        dif    = {1'b0, a_q} + {1'b0, ~b_q} + (N+1)'(1);
        // Carry out of A + ~B + 1 is set when no borrow occurred.
        borrow = ~dif[N];

        z_d    = '0;
        cout_d = 1'b0;
        neg_d  = 1'b0;
        ovf_d  = 1'b0;

        unique case (op_q)
            OP_ADD: begin
                z_d    = sum[N-1:0];
                cout_d = sum[N];
                neg_d  = sum[N-1];
                ovf_d  = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
            end
            OP_SUB: begin
                z_d    = dif[N-1:0];
                cout_d = borrow;
                neg_d  = dif[N-1];
                ovf_d  = (a_q[N-1] != b_q[N-1]) && (dif[N-1] != a_q[N-1]);
            end
            OP_ABSDIFF: begin
                // On borrow, negate the wrapped A-B to get B-A.
                z_d    = borrow ? (~dif[N-1:0] + N'(1)) : dif[N-1:0];
                cout_d = borrow;
                neg_d  = borrow;
            end
            OP_SATADD: begin
                z_d    = sum[N] ? '1 : sum[N-1:0];
                cout_d = sum[N];
                ovf_d  = sum[N];
            end
            default: ;
        endcase

        zero_d = (z_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            s1_valid_q <= 1'b0;
        end else if (accept) begin
            a_q        <= A;
            b_q        <= B;
            op_q       <= op_e'(op);
            s1_valid_q <= 1'b1;
        end else if (adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q        <= '0;
            cout_q     <= 1'b0;
            neg_q      <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            s2_valid_q <= 1'b0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                z_q    <= z_d;
                cout_q <= cout_d;
                neg_q  <= neg_d;
                zero_q <= zero_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid     = s2_valid_q;
    assign z             = z_q;
    assign cout          = cout_q;
    assign negative_flag = neg_q;
    assign zero_flag     = zero_q;
    assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_n_addsub_pipe.sv
// Testbench for n_addsub_pipe: directed vector table, backpressure and
// mid-stream reset sequences, N=32 corner cases, and randomized traffic
// checked against an arithmetic reference model through a scoreboard.
module tb_n_addsub_pipe;

    typedef struct packed {
        logic [7:0] z;
        logic       c;
        logic       n;
        logic       zf;
        logic       o;
    } res_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] z;
        logic       c;
        logic       n;
        logic       zf;
        logic       o;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    // N=8 instance
    logic       iv8, ir8, ov8, or8;
    logic [1:0] op8;
    logic [7:0] a8, b8, z8;
    logic       c8, n8, zf8, o8;

    // N=32 instance
    logic        iv32, ir32, ov32, or32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, z32;
    logic        c32, n32, zf32, o32;

    int errors = 0;
    int checks = 0;

    res_t        exp_q[$];
    logic [7:0]  got_q[$];
    vec_t        vt[8];

    always #5 clk = ~clk;

    n_addsub_pipe #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .op(op8), .A(a8), .B(b8),
        .out_valid(ov8), .out_ready(or8), .z(z8), .cout(c8),
        .negative_flag(n8), .zero_flag(zf8), .overflow_flag(o8)
    );

    n_addsub_pipe #(.N(32)) u32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ir32), .op(op32), .A(a32), .B(b32),
        .out_valid(ov32), .out_ready(or32), .z(z32), .cout(c32),
        .negative_flag(n32), .zero_flag(zf32), .overflow_flag(o32)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the mode definitions.
    function automatic res_t model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        res_t r;
        int ia, ib, sa, sb, s;
        ia = int'(a);
        ib = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = '0;
        case (o)
            2'd0: begin
                s   = ia + ib;
                r.z = 8'(s);
                r.c = (s > 255);
                r.n = (r.z >= 8'h80);
                r.o = (sa + sb > 127) || (sa + sb < -128);
            end
            2'd1: begin
                s   = ia - ib;
                r.z = 8'(s);
                r.c = (ia < ib);
                r.n = (r.z >= 8'h80);
                r.o = (sa - sb > 127) || (sa - sb < -128);
            end
            2'd2: begin
                r.z = 8'((ia >= ib) ? ia - ib : ib - ia);
                r.c = (ia < ib);
                r.n = (ia < ib);
            end
            default: begin
                s   = ia + ib;
                r.z = (s > 255) ? 8'hFF : 8'(s);
                r.c = (s > 255);
                r.o = (s > 255);
            end
        endcase
        r.zf = (r.z == 8'h00);
        return r;
    endfunction

    // One clock for the N=8 unit: handshakes are observed mid-cycle,
    // then inputs may be changed 1 time unit after the rising edge.
    task automatic step8();
        res_t e;
        @(negedge clk);
        if (iv8 && ir8) exp_q.push_back(model(op8, a8, b8));
        if (ov8 && or8) begin
            got_q.push_back(z8);
            if (exp_q.size() == 0) begin
                chk("sb_spurious_output", 32'(z8), 32'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("sb_result", 32'({z8, c8, n8, zf8, o8}), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic direct8(input vec_t v);
        op8 = v.op; a8 = v.a; b8 = v.b; iv8 = 1'b1; or8 = 1'b1;
        chk("dir_in_ready", 32'(ir8), 32'd1);
        step8();                                  // accepted into stage 1
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom);
        chk("dir_not_yet_valid", 32'(ov8), 32'd0);
        step8();                                  // moved into stage 2
        chk("dir_out_valid", 32'(ov8), 32'd1);
        chk("dir_z", 32'(z8), 32'(v.z));
        chk("dir_cout", 32'(c8), 32'(v.c));
        chk("dir_neg", 32'(n8), 32'(v.n));
        chk("dir_zero", 32'(zf8), 32'(v.zf));
        chk("dir_ovf", 32'(o8), 32'(v.o));
        step8();                                  // consumed
        chk("dir_drained", 32'(ov8), 32'd0);
    endtask

    task automatic direct32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ez, input logic ec, input logic en,
                            input logic ezf, input logic eo);
        op32 = o; a32 = a; b32 = b; iv32 = 1'b1; or32 = 1'b1;
        chk("d32_in_ready", 32'(ir32), 32'd1);
        @(posedge clk); #1;
        iv32 = 1'b0; a32 = $urandom; b32 = $urandom;
        chk("d32_not_yet_valid", 32'(ov32), 32'd0);
        @(posedge clk); #1;
        chk("d32_out_valid", 32'(ov32), 32'd1);
        chk("d32_z", z32, ez);
        chk("d32_cout", 32'(c32), 32'(ec));
        chk("d32_neg", 32'(n32), 32'(en));
        chk("d32_zero", 32'(zf32), 32'(ezf));
        chk("d32_ovf", 32'(o32), 32'(eo));
        @(posedge clk); #1;
        chk("d32_drained", 32'(ov32), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int issued;
        logic acc;
        vec_t v;

        //            op     A      B      z      c     n     zf    o
        vt[0] = '{2'b01, 8'h05, 8'h09, 8'hFC, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[1] = '{2'b10, 8'h05, 8'h09, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[2] = '{2'b10, 8'h09, 8'h09, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3] = '{2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[4] = '{2'b11, 8'hF0, 8'h20, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[5] = '{2'b01, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[6] = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[7] = '{2'b11, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        iv32 = 1'b0; or32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_z", 32'(z8), 32'd0);
        chk("rst_flags", 32'({c8, n8, zf8, o8}), 32'd0);
        chk("rst_in_ready", 32'(ir8), 32'd0);
        chk("rst_out_valid32", 32'(ov32), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(ir8), 32'd1);
        chk("post_rst_out_valid", 32'(ov8), 32'd0);

        // Directed vector table
        for (int i = 0; i < 8; i++) direct8(vt[i]);

        // Backpressure: two accepts fill the pipe, output held stable
        got_q.delete();
        or8 = 1'b0; op8 = 2'b00; a8 = 8'd1; b8 = 8'd1; iv8 = 1'b1;
        step8();
        a8 = 8'd2; b8 = 8'd2;
        step8();
        chk("bp_in_ready_low", 32'(ir8), 32'd0);
        chk("bp_out_valid", 32'(ov8), 32'd1);
        chk("bp_z_first", 32'(z8), 32'h02);
        a8 = 8'd3; b8 = 8'd3;
        repeat (2) begin
            step8();
            chk("bp_z_held", 32'(z8), 32'h02);
            chk("bp_in_ready_held", 32'(ir8), 32'd0);
        end
        or8 = 1'b1;
        #1;
        chk("bp_in_ready_comb", 32'(ir8), 32'd1);
        issued = 2;
        for (int c = 0; c < 12; c++) begin
            acc = iv8 && ir8;
            step8();
            if (acc) begin
                issued++;
                if (issued < 4) begin
                    a8 = 8'(issued + 1); b8 = 8'(issued + 1);
                end else begin
                    iv8 = 1'b0;
                end
            end
        end
        chk("bp_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size()) chk("bp_order", 32'(got_q[i]), 32'(2 * (i + 1)));

        // Reset mid-stream with two entries in flight
        or8 = 1'b0; op8 = 2'b01; a8 = 8'd10; b8 = 8'd3; iv8 = 1'b1;
        step8();
        a8 = 8'd20; b8 = 8'd5;
        step8();
        iv8 = 1'b0;
        chk("mr_pre_valid", 32'(ov8), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(ov8), 32'd0);
        chk("mr_z", 32'(z8), 32'd0);
        chk("mr_flags", 32'({c8, n8, zf8, o8}), 32'd0);
        chk("mr_in_ready", 32'(ir8), 32'd0);
        exp_q.delete();
        #1 rst_n = 1'b1;
        or8 = 1'b1;
        repeat (3) begin
            step8();
            chk("mr_no_stale", 32'(ov8), 32'd0);
        end
        v = '{2'b01, 8'd3, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        direct8(v);

        // N=32 corners
        direct32(2'b01, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        direct32(2'b00, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            iv8 = ($urandom_range(0, 9) < 7);
            or8 = ($urandom_range(0, 9) < 7);
            op8 = 2'($urandom);
            a8  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            b8  = ($urandom_range(0, 7) == 0) ? a8 : 8'($urandom);
            step8();
        end
        iv8 = 1'b0; or8 = 1'b1;
        repeat (6) step8();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_out_valid", 32'(ov8), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
